// File: rtl/serial_word_feeder.sv
// serial_word_feeder: parallel-to-serial front end for the serial pattern detector.
// Accepts WIDTH-bit words on a valid/ready handshake and shifts them out MSB first,
// one bit per clock, with the line held at 0 whenever no bit is being presented.
// Optional feature macro: SERIAL_FEEDER_PARITY_EN appends an even-parity bit per word.
module serial_word_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             abort,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

`ifdef SERIAL_FEEDER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  // Bits of the current word not yet on the line, MSB-aligned; the MSB goes
  // straight to serial_out on accept, so only the remainder is stored here.
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;
  logic             accept;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic             par;
`endif

  assign busy     = (state != IDLE);
  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
  // Abort takes priority over a handshake while a word is in flight.
  assign accept   = word_valid & word_ready & ~(abort & busy);

  // Ready decodes from state: idle, or the cycle whose successor can be a new MSB.
  always_comb begin
    word_ready = 1'b0;
    case (state)
      IDLE:   word_ready = 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
      SHIFT:  word_ready = 1'b0;
      PARITY: word_ready = 1'b1;
`else
      SHIFT:  word_ready = last_bit;
`endif
      default: word_ready = 1'b0;
    endcase
  end

  // Serializer FSM with registered line outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      par          <= 1'b0;
`endif
    end else if (abort && busy) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
    end else if (accept) begin
      state        <= SHIFT;
      shreg        <= {word_in[WIDTH-2:0], 1'b0};
      bit_cnt      <= '0;
      serial_out   <= word_in[WIDTH-1];
      serial_valid <= 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
      par          <= ^word_in;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (!last_bit) begin
            shreg      <= {shreg[WIDTH-2:0], 1'b0};
            serial_out <= shreg[WIDTH-1];
            bit_cnt    <= bit_cnt + CNT_W'(1);
          end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
            state        <= PARITY;
            serial_out   <= par;
`else
            state        <= IDLE;
            bit_cnt      <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
`endif
          end
        end
`ifdef SERIAL_FEEDER_PARITY_EN
        PARITY: begin
          state        <= IDLE;
          bit_cnt      <= '0;
          serial_out   <= 1'b0;
          serial_valid <= 1'b0;
        end
`endif
        default: begin
          serial_out   <= 1'b0;
          serial_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: directed scenarios plus randomized traffic,
// checked against a queue-based model of the serial line and a scoreboard.
module tb_serial_word_feeder;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] word_in = '0;
  logic             word_valid = 1'b0;
  logic             abort = 1'b0;
  logic             word_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;

  // cur_q: model of the line; cur_q[0] is the bit shown in the current cycle.
  // exp_q: scoreboard of bits still to be observed by the monitor.
  bit cur_q[$];
  bit exp_q[$];

  serial_word_feeder #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .abort        (abort),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every presented bit must match the next scoreboard entry.
  always @(negedge clock) begin
    if (reset_n) begin
      if (serial_valid === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected serial bit", 32'd1, 32'd0);
        else check("serial bit", {31'd0, serial_out}, {31'd0, exp_q.pop_front()});
      end else begin
        check("idle line level", {31'd0, serial_out}, 32'd0);
      end
    end
  end

  function automatic void push_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      cur_q.push_back(w[i]);
      exp_q.push_back(w[i]);
    end
`ifdef SERIAL_FEEDER_PARITY_EN
    cur_q.push_back(bit'($countones(w) % 2));
    exp_q.push_back(bit'($countones(w) % 2));
`endif
  endfunction

  // One clock of stimulus, entered and left at a falling edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] w, input logic a, output bit acc);
    bit m_ready, m_busy;
    word_valid = v;
    word_in    = w;
    abort      = a;
    m_busy  = (cur_q.size() > 0);
    m_ready = (cur_q.size() <= 1);
    check("word_ready", {31'd0, word_ready}, {31'd0, m_ready});
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("serial_valid", {31'd0, serial_valid}, {31'd0, m_busy});
    @(posedge clock);
    acc = 1'b0;
    if (m_busy && a) begin
      cur_q.delete();
      exp_q.delete();
    end else begin
      if (m_busy) void'(cur_q.pop_front());
      if (v && m_ready) begin
        push_word(w);
        acc = 1'b1;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, WIDTH'($urandom), 1'b0, acc);
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      step(1'b1, w, 1'b0, acc);
      tries++;
    end
    if (!acc) check("accept timeout", 32'd0, 32'd1);
  endtask

  // Asynchronous reset applied between clock edges; outputs checked immediately.
  task automatic do_reset(input int cycles);
    @(posedge clock);
    #2;
    reset_n    = 1'b0;
    word_valid = 1'b0;
    abort      = 1'b0;
    #1;
    check("reset serial_out", {31'd0, serial_out}, 32'd0);
    check("reset serial_valid", {31'd0, serial_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset word_ready", {31'd0, word_ready}, 32'd1);
    cur_q.delete();
    exp_q.delete();
    repeat (cycles) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    bit acc;
    do_reset(2);

    // Reset mid-word, then a single word
    send(8'hA7);
    idle(3);
    do_reset(3);
    send(8'hE5);
    idle(WIDTH + 4);

    // Back-to-back words with valid held high
    send(8'hFF);
    send(8'h00);
    idle(WIDTH + 4);

    // Abort on the third serial bit, then a fresh word
    send(8'hF0);
    step(1'b0, '0, 1'b0, acc);
    step(1'b1, 8'h3C, 1'b1, acc);
    if (acc) check("accept during abort", 32'd1, 32'd0);
    idle(2);
    send(8'h81);
    idle(WIDTH + 4);

    // Abort while idle has no effect on a simultaneous accept
    step(1'b1, 8'h5A, 1'b1, acc);
    idle(WIDTH + 4);

    // Stall: no valid for 10 cycles
    idle(10);

    // Parity-relevant pair
    send(8'hE5);
    send(8'h03);
    idle(WIDTH + 4);

    // Randomized traffic with occasional abort and reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        step($urandom_range(0, 3) != 0, WIDTH'($urandom),
             $urandom_range(0, 24) == 0, acc);
      end
    end
    idle(WIDTH + 4);
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
